// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;

    // One in-order buffer slot: the fetch PC, the returned word and whether it has arrived.
    // Field widths follow XLEN_DEFAULT; the fetch stage is built at that width.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
        logic                    filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory-request/response and decode handshake bundle of the fetch stage.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_rsp_valid_i;
    logic [XLEN-1:0] imem_rsp_data_i;
    logic            if_valid_o;
    logic            if_ready_i;
    logic [XLEN-1:0] if_pc_o;
    logic [XLEN-1:0] if_instr_o;

    modport master (
        output imem_req_valid_o, imem_req_addr_o, if_valid_o, if_pc_o, if_instr_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, if_ready_i
    );

    modport slave (
        input  imem_req_valid_o, imem_req_addr_o, if_valid_o, if_pc_o, if_instr_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, if_ready_i
    );
endinterface

// File: rtl/fetch_buffer.sv
// Circular in-order buffer pairing each fetch PC with its returned instruction word.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_alloc,
    input  logic [XLEN-1:0]          i_alloc_pc,
    input  logic                     i_fill,
    input  logic [XLEN-1:0]          i_fill_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic                     o_head_valid,
    output logic [XLEN-1:0]          o_head_pc,
    output logic [XLEN-1:0]          o_head_instr,
    output logic [$clog2(DEPTH):0]   o_alloc_cnt,
    output logic [$clog2(DEPTH):0]   o_pend_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_alloc_ptr;
    logic [PW-1:0] r_fill_ptr;
    logic [PW-1:0] r_head_ptr;
    logic [CW-1:0] r_alloc_cnt;
    logic [CW-1:0] r_pend_cnt;

    // Allocate at the tail, fill the oldest pending slot, retire the head; clear wins over all.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_alloc_ptr <= {PW{1'b0}};
            r_fill_ptr  <= {PW{1'b0}};
            r_head_ptr  <= {PW{1'b0}};
            r_alloc_cnt <= {CW{1'b0}};
            r_pend_cnt  <= {CW{1'b0}};
        end else if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].filled <= 1'b0;
            end
            r_alloc_ptr <= {PW{1'b0}};
            r_fill_ptr  <= {PW{1'b0}};
            r_head_ptr  <= {PW{1'b0}};
            r_alloc_cnt <= {CW{1'b0}};
            r_pend_cnt  <= {CW{1'b0}};
        end else begin
            // A slot being allocated is never the fill target, and a popped slot is
            // always filled, so these three writes never collide on the same field value.
            if (i_alloc) begin
                r_mem[r_alloc_ptr].pc     <= i_alloc_pc;
                r_mem[r_alloc_ptr].filled <= 1'b0;
                r_alloc_ptr               <= r_alloc_ptr + PW'(1'b1);
            end
            if (i_fill) begin
                r_mem[r_fill_ptr].instr  <= i_fill_data;
                r_mem[r_fill_ptr].filled <= 1'b1;
                r_fill_ptr               <= r_fill_ptr + PW'(1'b1);
            end
            if (i_pop) begin
                r_mem[r_head_ptr].filled <= 1'b0;
                r_head_ptr               <= r_head_ptr + PW'(1'b1);
            end
            r_alloc_cnt <= r_alloc_cnt + CW'(i_alloc) - CW'(i_pop);
            r_pend_cnt  <= r_pend_cnt + CW'(i_alloc) - CW'(i_fill);
        end
    end

    assign o_head_valid = (r_alloc_cnt != {CW{1'b0}}) & r_mem[r_head_ptr].filled;
    assign o_head_pc    = r_mem[r_head_ptr].pc;
    assign o_head_instr = r_mem[r_head_ptr].instr;
    assign o_alloc_cnt  = r_alloc_cnt;
    assign o_pend_cnt   = r_pend_cnt;

endmodule

// File: rtl/fetch_unit_chk.sv
// Protocol and counter-range checks for the fetch stage (simulation only).
module fetch_unit_chk #(
    parameter int DEPTH = 2
) (
    input logic                   clk,
    input logic                   reset,
    input logic                   i_rsp_valid,
    input logic [$clog2(DEPTH):0] i_discard_cnt,
    input logic [$clog2(DEPTH):0] i_pend_cnt,
    input logic [$clog2(DEPTH)+1:0] i_discard_sum
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        !(i_rsp_valid && (i_discard_cnt == {CW{1'b0}}) && (i_pend_cnt == {CW{1'b0}})))
        else $error("fetch_unit: response arrived with no pending fetch");

    a_discard_range: assert property (@(posedge clk) disable iff (reset)
        (i_discard_sum <= SW'(DEPTH)))
        else $error("fetch_unit: discard count out of range");

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues PC-addressed requests, tags responses, drops stale ones after redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_advance_o,
    input  logic            flush_i,
    fetch_unit_if.master    bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [CW-1:0]   w_alloc_cnt;
    logic [CW-1:0]   w_pend_cnt;
    logic [CW-1:0]   r_discard_cnt;
    logic [SW-1:0]   w_discard_sum;
    logic            w_pop;
    logic            w_issue;
    logic            w_alloc;
    logic            w_fill;
    logic            w_drop;
    logic            w_head_valid;
    logic [XLEN-1:0] w_head_pc;
    logic [XLEN-1:0] w_head_instr;

    // A slot freed by this cycle's pop can be reused by this cycle's request.
    assign w_pop   = w_head_valid & bus.if_ready_i;
    assign w_issue = ~reset & ~flush_i & ((w_alloc_cnt - CW'(w_pop)) < CW'(DEPTH));
    assign w_alloc = w_issue & bus.imem_req_ready_i;

    // Responses owed to pre-redirect requests are consumed by the discard counter first.
    assign w_drop = bus.imem_rsp_valid_i & (r_discard_cnt != {CW{1'b0}});
    assign w_fill = bus.imem_rsp_valid_i & (r_discard_cnt == {CW{1'b0}});

    assign bus.imem_req_valid_o = w_issue;
    assign bus.imem_req_addr_o  = pc_i;
    assign pc_advance_o         = w_alloc;
    assign bus.if_valid_o       = w_head_valid;
    assign bus.if_pc_o          = w_head_pc;
    assign bus.if_instr_o       = w_head_instr;

    // Next discard count: on redirect every unanswered request becomes a discard,
    // less the one response (kept or dropped) that lands in the redirect cycle.
    always_comb begin
        w_discard_sum = {1'b0, r_discard_cnt};
        if (flush_i) begin
            w_discard_sum = {1'b0, w_pend_cnt} + {1'b0, r_discard_cnt}
                          - SW'(bus.imem_rsp_valid_i);
        end else if (w_drop) begin
            w_discard_sum = {1'b0, r_discard_cnt} - SW'(1'b1);
        end else begin
            w_discard_sum = {1'b0, r_discard_cnt};
        end
    end

    // Discard counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_discard_cnt <= {CW{1'b0}};
        end else begin
            r_discard_cnt <= w_discard_sum[CW-1:0];
        end
    end

    fetch_buffer #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk          (clk),
        .reset        (reset),
        .i_alloc      (w_alloc),
        .i_alloc_pc   (pc_i),
        .i_fill       (w_fill),
        .i_fill_data  (bus.imem_rsp_data_i),
        .i_pop        (w_pop),
        .i_clear      (flush_i),
        .o_head_valid (w_head_valid),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr),
        .o_alloc_cnt  (w_alloc_cnt),
        .o_pend_cnt   (w_pend_cnt)
    );

    fetch_unit_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk           (clk),
        .reset         (reset),
        .i_rsp_valid   (bus.imem_rsp_valid_i),
        .i_discard_cnt (r_discard_cnt),
        .i_pend_cnt    (w_pend_cnt),
        .i_discard_sum (w_discard_sum)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: bench-side PC register and in-order memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [XLEN-1:0] pc_i;
    logic            pc_advance_o;
    logic            flush_i;

    fetch_unit_if #(.XLEN(XLEN)) bus ();

    fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_i         (pc_i),
        .pc_advance_o (pc_advance_o),
        .flush_i      (flush_i),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    exp_t        sb[$];
    mreq_t       memq[$];
    int          n_checks;
    int          n_errors;
    int          cyc;
    int          mem_lat;
    logic [31:0] redirect_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE000_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: observe handshakes mid-cycle, then update PC register and memory after the edge.
    task automatic tick();
        logic        fire;
        logic        fl;
        logic [31:0] fa;
        logic [31:0] fpc;
        @(negedge clk);
        fire = bus.imem_req_valid_o & bus.imem_req_ready_i;
        fa   = bus.imem_req_addr_o;
        fpc  = pc_i;
        fl   = flush_i;
        if (fire) begin
            memq.push_back('{addr: fa, due: cyc + mem_lat});
            sb.push_back('{pc: fpc, instr: mem_word(fpc)});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (fl) begin
            pc_i = redirect_pc;
            sb.delete();
        end else if (fire) begin
            pc_i = pc_i + 32'd4;
        end
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            bus.imem_rsp_valid_i = 1'b1;
            bus.imem_rsp_data_i  = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            bus.imem_rsp_valid_i = 1'b0;
            bus.imem_rsp_data_i  = 32'h0;
        end
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        reset = 1'b1;
        #1;
        memq.delete();
        sb.delete();
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = 32'h0;
        flush_i = 1'b0;
        pc_i    = start_pc;
        tick();
        tick();
    endtask

    task automatic release_rst();
        reset = 1'b0;
        cyc   = 0;
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_valid"}, 32'(bus.imem_req_valid_o), 32'h0);
        chk({tag, "_pc_adv"},    32'(pc_advance_o),         32'h0);
        chk({tag, "_if_valid"},  32'(bus.if_valid_o),       32'h0);
        chk({tag, "_if_pc"},     bus.if_pc_o,               32'h0);
        chk({tag, "_if_instr"},  bus.if_instr_o,            32'h0);
    endtask

    task automatic wait_ifv(input string tag);
        int n = 0;
        while (bus.if_valid_o !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chk({tag, "_ifv_seen"}, 32'(bus.if_valid_o), 32'h1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        bus.imem_req_ready_i = 1'b0;
        bus.if_ready_i       = 1'b1;
        while (sb.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_drain_left"}, 32'(sb.size()), 32'h0);
    endtask

    // Monitor: every decode handshake must match the oldest expected {pc, instr}.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.if_valid_o === 1'b1 && bus.if_ready_i === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: got pc %h instr %h expected nothing",
                             bus.if_pc_o, bus.if_instr_o);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", bus.if_pc_o, e.pc);
                    chk("sb_instr", bus.if_instr_o, e.instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        mem_lat = 1;
        redirect_pc = 32'h0;
        pc_i = 32'h0;
        flush_i = 1'b0;
        bus.imem_req_ready_i = 1'b1;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = 32'h0;
        bus.if_ready_i       = 1'b1;

        // Test 1: streaming at full rate, then a redirect mid-stream.
        do_reset(32'h0);
        chk_zero("t1_rst");
        release_rst();
        chk("t1_c0_req", 32'(bus.imem_req_valid_o), 32'h1);
        chk("t1_c0_addr", bus.imem_req_addr_o, 32'h0);
        tick();
        chk("t1_c1_ifv", 32'(bus.if_valid_o), 32'h0);
        chk("t1_c1_addr", bus.imem_req_addr_o, 32'h4);
        tick();
        chk("t1_c2_ifv", 32'(bus.if_valid_o), 32'h1);
        chk("t1_c2_pc", bus.if_pc_o, 32'h0);
        chk("t1_c2_instr", bus.if_instr_o, 32'hE000_0000);
        chk("t1_c2_req", 32'(bus.imem_req_valid_o), 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t1_stream_req", 32'(bus.imem_req_valid_o), 32'h1);
        end
        redirect_pc = 32'h200;
        flush_i = 1'b1;
        #1;
        chk("t1_flush_req", 32'(bus.imem_req_valid_o), 32'h0);
        tick();
        flush_i = 1'b0;
        #1;
        chk("t1_postflush_ifv", 32'(bus.if_valid_o), 32'h0);
        chk("t1_postflush_addr", bus.imem_req_addr_o, 32'h200);
        wait_ifv("t1");
        chk("t1_redir_pc", bus.if_pc_o, 32'h200);
        for (int i = 0; i < 3; i++) tick();
        drain("t1");

        // Test 2: decode stalled fills the buffer, release reissues alongside the pop.
        do_reset(32'h0);
        bus.imem_req_ready_i = 1'b1;
        bus.if_ready_i = 1'b0;
        mem_lat = 1;
        release_rst();
        tick();
        tick();
        chk("t2_c2_req", 32'(bus.imem_req_valid_o), 32'h0);
        chk("t2_c2_adv", 32'(pc_advance_o), 32'h0);
        chk("t2_c2_pc", bus.if_pc_o, 32'h0);
        tick();
        chk("t2_c3_req", 32'(bus.imem_req_valid_o), 32'h0);
        chk("t2_c3_ifv", 32'(bus.if_valid_o), 32'h1);
        bus.if_ready_i = 1'b1;
        #1;
        chk("t2_pop_req", 32'(bus.imem_req_valid_o), 32'h1);
        chk("t2_pop_adv", 32'(pc_advance_o), 32'h1);
        chk("t2_pop_addr", bus.imem_req_addr_o, 32'h8);
        for (int i = 0; i < 4; i++) tick();
        drain("t2");

        // Test 3: memory refuses requests for three cycles.
        do_reset(32'h0);
        bus.if_ready_i = 1'b1;
        bus.imem_req_ready_i = 1'b0;
        mem_lat = 1;
        release_rst();
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_req", 32'(bus.imem_req_valid_o), 32'h1);
            chk("t3_stall_addr", bus.imem_req_addr_o, 32'h0);
            chk("t3_stall_adv", 32'(pc_advance_o), 32'h0);
            tick();
        end
        bus.imem_req_ready_i = 1'b1;
        #1;
        chk("t3_go_adv", 32'(pc_advance_o), 32'h1);
        tick();
        chk("t3_next_addr", bus.imem_req_addr_o, 32'h4);
        for (int i = 0; i < 4; i++) tick();
        drain("t3");

        // Test 4: redirect with two requests outstanding at 3-cycle latency.
        do_reset(32'h10);
        bus.if_ready_i = 1'b1;
        bus.imem_req_ready_i = 1'b1;
        mem_lat = 3;
        release_rst();
        tick();
        chk("t4_c1_addr", bus.imem_req_addr_o, 32'h14);
        tick();
        chk("t4_c2_full", 32'(bus.imem_req_valid_o), 32'h0);
        redirect_pc = 32'h100;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        chk("t4_resume_addr", bus.imem_req_addr_o, 32'h100);
        chk("t4_resume_ifv", 32'(bus.if_valid_o), 32'h0);
        wait_ifv("t4");
        chk("t4_first_pc", bus.if_pc_o, 32'h100);
        chk("t4_first_instr", bus.if_instr_o, 32'hE000_0100);
        drain("t4");

        // Test 5: redirect in the cycle a response lands with one more pending.
        do_reset(32'h20);
        bus.if_ready_i = 1'b1;
        bus.imem_req_ready_i = 1'b1;
        mem_lat = 2;
        release_rst();
        tick();
        tick();
        chk("t5_c2_rsp", 32'(bus.imem_rsp_valid_i), 32'h1);
        redirect_pc = 32'h300;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        wait_ifv("t5");
        chk("t5_first_pc", bus.if_pc_o, 32'h300);
        chk("t5_first_instr", bus.if_instr_o, 32'hE000_0300);
        drain("t5");

        // Test 6: asynchronous reset with a full buffer, then clean restart.
        do_reset(32'h40);
        bus.if_ready_i = 1'b0;
        bus.imem_req_ready_i = 1'b1;
        mem_lat = 1;
        release_rst();
        for (int i = 0; i < 4; i++) tick();
        chk("t6_full_ifv", 32'(bus.if_valid_o), 32'h1);
        chk("t6_full_pc", bus.if_pc_o, 32'h40);
        reset = 1'b1;
        #1;
        chk_zero("t6_async");
        do_reset(32'h80);
        bus.if_ready_i = 1'b1;
        bus.imem_req_ready_i = 1'b1;
        release_rst();
        chk("t6_restart_addr", bus.imem_req_addr_o, 32'h80);
        tick();
        tick();
        chk("t6_restart_pc", bus.if_pc_o, 32'h80);
        chk("t6_restart_instr", bus.if_instr_o, 32'hE000_0080);
        for (int i = 0; i < 3; i++) tick();
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
